id_token_tracker: RTL and testbench

Downstream consumer of the identifier-recognizer FSM (`id_fsm`). It samples the character stream together with the recognizer's per-character `out` flag and detects where each identifier run begins and ends. Each completed run becomes a token record: length, first character and an optional hash. Records are queued in a small FIFO and drained over a valid/ready handshake, with a saturating token counter and a sticky overflow flag.

---
 rtl/id_pkg.sv | 26 ++
 rtl/id_tok_fifo.sv | 56 +++++
 rtl/id_token_tracker.sv | 150 +++++++++++++++
 tb/tb_id_token_tracker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared definitions for the identifier token tracker: FSM state encoding,
// token record field widths and the rolling hash step.
package id_pkg;

    localparam int CHAR_W = 8;
    localparam int HASH_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        IN_ID = 1'b1
    } state_t;

    // First character and hash of a run; the length field is sized by the
    // tracker's LEN_W parameter and packed alongside this.
    typedef struct packed {
        logic [CHAR_W-1:0] first;
        logic [HASH_W-1:0] hash;
    } tok_tag_t;

    // One hash step: rotate the running hash left by one and fold in the char.
    function automatic logic [HASH_W-1:0] hash_step(input logic [HASH_W-1:0] h,
                                                    input logic [CHAR_W-1:0] c);
        return {h[HASH_W-2:0], h[HASH_W-1]} ^ c;
    endfunction

endpackage

// File: rtl/id_tok_fifo.sv
// Small synchronous record FIFO with asynchronous active-low reset.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is accepted only if a pop happens in the same cycle.
module id_tok_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Status flags, guarded push/pop and next pointers; the head reads as zero when empty.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers, cleared by reset so the FIFO comes up empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Record storage; contents are never observed while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/id_token_tracker.sv
// Tracks identifier runs flagged by id_fsm and turns each completed run into
// a token record (length, first char, optional hash) queued in a FIFO.
// Optional feature macro: ID_TOKEN_HASH_EN adds the rolling hash per record;
// without it tok_hash is tied to zero and no hash logic exists.
module id_token_tracker
    import id_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [7:0]        char,
    input  logic              id_out,
    input  logic              flush,
    output logic              tok_vld,
    input  logic              tok_rdy,
    output logic [LEN_W-1:0]  tok_len,
    output logic [7:0]        tok_first,
    output logic [7:0]        tok_hash,
    output logic [CNT_W-1:0]  tok_cnt,
    output logic              ovf
);

`ifdef ID_TOKEN_HASH_EN
    localparam int DATA_W = LEN_W + CHAR_W + HASH_W;
`else
    localparam int DATA_W = LEN_W + CHAR_W;
`endif

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CHAR_W-1:0] first_q, first_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
`ifdef ID_TOKEN_HASH_EN
    logic [HASH_W-1:0] hash_q, hash_d;
`endif

    logic              term;
    logic              tok_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    assign tok_vld = ~fifo_empty;
    assign tok_pop = tok_vld & tok_rdy;

    // Run FSM next state: start, extend or terminate a run, then apply flush
    // after the same-cycle char so a starting/extending char is included.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        term    = 1'b0;
`ifdef ID_TOKEN_HASH_EN
        hash_d  = hash_q;
`endif
        if (in_vld) begin
            if (state_q == IDLE) begin
                if (id_out) begin
                    state_d = IN_ID;
                    len_d   = LEN_W'(1);
                    first_d = char;
`ifdef ID_TOKEN_HASH_EN
                    hash_d  = char;
`endif
                end
            end else if (id_out) begin
                if (len_q != '1) begin
                    len_d = len_q + LEN_W'(1);
                end
`ifdef ID_TOKEN_HASH_EN
                hash_d = hash_step(hash_q, char);
`endif
            end else begin
                term    = 1'b1;
                state_d = IDLE;
            end
            if (flush && (state_d == IN_ID)) begin
                term    = 1'b1;
                state_d = IDLE;
            end
        end
        if (term && fifo_full && !tok_pop) begin
            ovf_d = 1'b1;
        end
        if (term && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
`ifdef ID_TOKEN_HASH_EN
        wr_data = {len_d, first_d, hash_d};
`else
        wr_data = {len_d, first_d};
`endif
    end

    // State, run registers, token counter and sticky overflow; reset discards any open run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            first_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef ID_TOKEN_HASH_EN
            hash_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
`ifdef ID_TOKEN_HASH_EN
            hash_q  <= hash_d;
`endif
        end
    end

    id_tok_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (term),
        .pop     (tok_pop),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tok_len   = rd_data[DATA_W-1 -: LEN_W];
    assign tok_first = rd_data[DATA_W-LEN_W-1 -: CHAR_W];
`ifdef ID_TOKEN_HASH_EN
    assign tok_hash  = rd_data[HASH_W-1:0];
`else
    assign tok_hash  = 8'h00;
`endif
    assign tok_cnt   = cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_id_token_tracker.sv
// Bench for id_token_tracker: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the token stream.
module tb_id_token_tracker;

    localparam int DEPTH   = 4;
    localparam int LEN_W   = 8;
    localparam int CNT_W   = 16;
    localparam int LEN_MAX = 255;
    localparam int CNT_MAX = 65535;
`ifdef ID_TOKEN_HASH_EN
    localparam bit HASH_ON = 1'b1;
`else
    localparam bit HASH_ON = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_vld;
    logic [7:0]       ch;
    logic             id_out;
    logic             flush;
    logic             tok_vld;
    logic             tok_rdy;
    logic [LEN_W-1:0] tok_len;
    logic [7:0]       tok_first;
    logic [7:0]       tok_hash;
    logic [CNT_W-1:0] tok_cnt;
    logic             ovf;

    typedef struct {
        int         len;
        logic [7:0] first;
        logic [7:0] hash;
    } rec_t;

    rec_t       m_q[$];
    bit         m_in_run;
    int         m_len;
    logic [7:0] m_first;
    logic [7:0] m_hash;
    int         m_cnt;
    bit         m_ovf;

    int checks;
    int errors;

    id_token_tracker #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (in_vld),
        .char      (ch),
        .id_out    (id_out),
        .flush     (flush),
        .tok_vld   (tok_vld),
        .tok_rdy   (tok_rdy),
        .tok_len   (tok_len),
        .tok_first (tok_first),
        .tok_hash  (tok_hash),
        .tok_cnt   (tok_cnt),
        .ovf       (ovf)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference hash: rotate-left-by-one written as arithmetic, then xor the char.
    function automatic logic [7:0] refHash(input logic [7:0] h, input logic [7:0] c);
        int r;
        r = ((int'(h) * 2) % 256) + (int'(h) / 128);
        return 8'(r) ^ c;
    endfunction

    task automatic modelReset();
        m_q.delete();
        m_in_run = 1'b0;
        m_len    = 0;
        m_first  = 8'h00;
        m_hash   = 8'h00;
        m_cnt    = 0;
        m_ovf    = 1'b0;
    endtask

    // One clock edge of the token-stream behaviour.
    task automatic modelStep(input logic vld, input logic [7:0] c, input logic idv,
                             input logic fl, input logic rdy);
        bit   pop;
        bit   was_full;
        bit   term;
        rec_t r;
        pop      = (m_q.size() > 0) && rdy;
        was_full = (m_q.size() == DEPTH);
        term     = 1'b0;
        if (vld) begin
            if (!m_in_run) begin
                if (idv) begin
                    m_in_run = 1'b1;
                    m_len    = 1;
                    m_first  = c;
                    m_hash   = c;
                end
            end else if (idv) begin
                m_len++;
                m_hash = refHash(m_hash, c);
            end else begin
                term     = 1'b1;
                m_in_run = 1'b0;
            end
            if (fl && m_in_run) begin
                term     = 1'b1;
                m_in_run = 1'b0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (term) begin
            r.len   = (m_len > LEN_MAX) ? LEN_MAX : m_len;
            r.first = m_first;
            r.hash  = m_hash;
            if (m_cnt < CNT_MAX) m_cnt++;
            if (!was_full || pop) m_q.push_back(r);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic checkAll();
        checkOutput("tok_vld", 32'(tok_vld), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            checkOutput("tok_len", 32'(tok_len), 32'(m_q[0].len));
            checkOutput("tok_first", 32'(tok_first), 32'(m_q[0].first));
            checkOutput("tok_hash", 32'(tok_hash), 32'(HASH_ON ? m_q[0].hash : 8'h00));
        end
        checkOutput("tok_cnt", 32'(tok_cnt), 32'(m_cnt));
        checkOutput("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    // Drive one cycle of inputs, advance model and DUT together, check after the edge.
    task automatic applyStimulus(input logic vld, input logic [7:0] c, input logic idv,
                                 input logic fl, input logic rdy);
        in_vld  = vld;
        ch      = c;
        id_out  = idv;
        flush   = fl;
        tok_rdy = rdy;
        @(posedge clk);
        modelStep(vld, c, idv, fl, rdy);
        #1;
        checkAll();
    endtask

    task automatic sendChars(input string s, input logic idv, input logic rdy);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(1'b1, s[i], idv, 1'b0, rdy);
        end
    endtask

    // Asynchronous reset pulse between edges; outputs must clear without a clock.
    task automatic applyReset();
        in_vld = 1'b0;
        flush  = 1'b0;
        rst_n  = 1'b0;
        #2;
        modelReset();
        checkOutput("rst_vld", 32'(tok_vld), 32'd0);
        checkOutput("rst_len", 32'(tok_len), 32'd0);
        checkOutput("rst_first", 32'(tok_first), 32'd0);
        checkOutput("rst_hash", 32'(tok_hash), 32'd0);
        checkOutput("rst_cnt", 32'(tok_cnt), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        #2;
        rst_n = 1'b1;
    endtask

    // Scenario sequence: directed plan items, then random traffic, then summary.
    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        ch      = 8'h00;
        id_out  = 1'b0;
        flush   = 1'b0;
        tok_rdy = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        applyReset();

        // Single identifier terminated by a space
        sendChars("abcd0123", 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        checkOutput("single_len", 32'(tok_len), 32'd8);
        checkOutput("single_first", 32'(tok_first), 32'h61);
        checkOutput("single_cnt", 32'(tok_cnt), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Hash of "ab"
        sendChars("ab", 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        checkOutput("hash_ab", 32'(tok_hash), 32'(HASH_ON ? 8'hA0 : 8'h00));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Flush on the starting char
        applyStimulus(1'b1, 8'h78, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_len", 32'(tok_len), 32'd1);
        checkOutput("flush_first", 32'(tok_first), 32'h78);
        checkOutput("flush_hash", 32'(tok_hash), 32'(HASH_ON ? 8'h78 : 8'h00));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Backpressure: five tokens into a four-entry FIFO
        applyReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h61 + i), 1'b1, 1'b0, 1'b0);
            applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("ovf_set", 32'(ovf), 32'd1);
        checkOutput("ovf_cnt", 32'(tok_cnt), 32'd5);
        checkOutput("ovf_head", 32'(tok_first), 32'h61);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Push and pop in the same cycle while full
        applyReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h61 + i), 1'b1, 1'b0, 1'b0);
            applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'h65, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b1);
        checkOutput("full_pp_ovf", 32'(ovf), 32'd0);
        checkOutput("full_pp_cnt", 32'(tok_cnt), 32'd5);
        checkOutput("full_pp_head", 32'(tok_first), 32'h62);
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Gaps inside an identifier, then a saturating long identifier
        applyReset();
        applyStimulus(1'b1, 8'h71, 1'b1, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 8'h55, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h72, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        checkOutput("gap_len", 32'(tok_len), 32'd2);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 8'h7A, 1'b1, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_len", 32'(tok_len), 32'd255);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a run discards it
        sendChars("abc", 1'b1, 1'b1);
        applyReset();
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b1);
        checkOutput("midrst_vld", 32'(tok_vld), 32'd0);
        checkOutput("midrst_cnt", 32'(tok_cnt), 32'd0);

        // Random traffic with stalls, gaps and flushes
        applyReset();
        for (int i = 0; i < 3000; i++) begin
            logic v;
            logic f;
            logic r;
            v = ($urandom % 4) != 0;
            f = v && (($urandom % 16) == 0);
            r = ((i / 64) % 3 == 2) ? 1'b0 : (($urandom % 3) != 0);
            applyStimulus(v, 8'($urandom), ($urandom % 3) != 0, f, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
